// File: rtl/cmp_window_tally.sv
// cmp_window_tally
// Accumulates the +1 / 0 / -1 comparison code stream over a window of
// WINDOW legal samples and hands a report (net sum plus per-class counts)
// downstream through a valid/ready pair. Illegal codes raise a sticky error
// but do not disturb the window. A flush forces an early report of a
// non-empty partial window.
module cmp_window_tally #(
   parameter  int WINDOW = 8,
   localparam int CNT_W  = $clog2(WINDOW + 1),
   localparam int SUM_W  = CNT_W + 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [4:0]       in_result,
   output logic             in_ready,
   input  logic             flush,
   input  logic             err_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_gt_cnt,
   output logic [CNT_W-1:0] out_eq_cnt,
   output logic [CNT_W-1:0] out_lt_cnt,
   output logic [CNT_W-1:0] out_len,
   output logic             err
);

   typedef enum logic [0:0] {
      ACCUM  = 1'b0,
      REPORT = 1'b1
   } state_t;

   localparam logic [4:0]       CODE_GT = 5'b00001;
   localparam logic [4:0]       CODE_EQ = 5'b00000;
   localparam logic [4:0]       CODE_LT = 5'b11111;
   localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(WINDOW);

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] gt_r, eq_r, lt_r;
   logic [CNT_W-1:0] gt_nxt_s, eq_nxt_s, lt_nxt_s;
   logic [CNT_W-1:0] gt_acc_s, eq_acc_s, lt_acc_s, len_acc_s;
   logic             is_gt_s, is_eq_s, is_lt_s, legal_s;
   logic             accept_s, load_s, err_nxt_s;
   logic             in_ready_r, out_valid_r, err_r;
   logic [SUM_W-1:0] out_sum_r;
   logic [CNT_W-1:0] out_gt_r, out_eq_r, out_lt_r, out_len_r;

   // Code classification and the counters as they would stand after this cycle's sample.
   always_comb begin
      is_gt_s  = (in_result == CODE_GT);
      is_eq_s  = (in_result == CODE_EQ);
      is_lt_s  = (in_result == CODE_LT);
      legal_s  = is_gt_s || is_eq_s || is_lt_s;
      accept_s = in_valid && (state_r == ACCUM);
      gt_acc_s = gt_r;
      eq_acc_s = eq_r;
      lt_acc_s = lt_r;
      if (accept_s && is_gt_s) begin
         gt_acc_s = gt_r + CNT_W'(1);
      end else if (accept_s && is_eq_s) begin
         eq_acc_s = eq_r + CNT_W'(1);
      end else if (accept_s && is_lt_s) begin
         lt_acc_s = lt_r + CNT_W'(1);
      end else begin
         gt_acc_s = gt_r;
      end
      len_acc_s = gt_acc_s + eq_acc_s + lt_acc_s;
   end

   // Next-state, counter update and report-capture decision.
   always_comb begin
      state_nxt_s = state_r;
      gt_nxt_s    = gt_r;
      eq_nxt_s    = eq_r;
      lt_nxt_s    = lt_r;
      load_s      = 1'b0;
      case (state_r)
         ACCUM: begin
            if ((accept_s && legal_s && (len_acc_s == WIN_LEN)) ||
                (flush && (len_acc_s != CNT_W'(0)))) begin
               // Report fields capture the final counts, so the counters
               // can restart immediately for the next window.
               state_nxt_s = REPORT;
               load_s      = 1'b1;
               gt_nxt_s    = CNT_W'(0);
               eq_nxt_s    = CNT_W'(0);
               lt_nxt_s    = CNT_W'(0);
            end else begin
               gt_nxt_s = gt_acc_s;
               eq_nxt_s = eq_acc_s;
               lt_nxt_s = lt_acc_s;
            end
         end
         REPORT: begin
            if (out_ready) begin
               state_nxt_s = ACCUM;
            end else begin
               state_nxt_s = REPORT;
            end
         end
         default: begin
            state_nxt_s = ACCUM;
            gt_nxt_s    = CNT_W'(0);
            eq_nxt_s    = CNT_W'(0);
            lt_nxt_s    = CNT_W'(0);
         end
      endcase
   end

   // Sticky error: an accepted illegal code wins over a coincident clear.
   always_comb begin
      if (accept_s && !legal_s) begin
         err_nxt_s = 1'b1;
      end else if (err_clr) begin
         err_nxt_s = 1'b0;
      end else begin
         err_nxt_s = err_r;
      end
   end

   // State, counters, handshake flags and error flag.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r     <= ACCUM;
         gt_r        <= CNT_W'(0);
         eq_r        <= CNT_W'(0);
         lt_r        <= CNT_W'(0);
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         err_r       <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         gt_r        <= gt_nxt_s;
         eq_r        <= eq_nxt_s;
         lt_r        <= lt_nxt_s;
         in_ready_r  <= (state_nxt_s == ACCUM);
         out_valid_r <= (state_nxt_s == REPORT);
         err_r       <= err_nxt_s;
      end
   end

   // Report fields: loaded on entry to REPORT, held until the next report.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_sum_r <= SUM_W'(0);
         out_gt_r  <= CNT_W'(0);
         out_eq_r  <= CNT_W'(0);
         out_lt_r  <= CNT_W'(0);
         out_len_r <= CNT_W'(0);
      end else if (load_s) begin
         out_sum_r <= SUM_W'(gt_acc_s) - SUM_W'(lt_acc_s);
         out_gt_r  <= gt_acc_s;
         out_eq_r  <= eq_acc_s;
         out_lt_r  <= lt_acc_s;
         out_len_r <= len_acc_s;
      end else begin
         out_sum_r <= out_sum_r;
         out_gt_r  <= out_gt_r;
         out_eq_r  <= out_eq_r;
         out_lt_r  <= out_lt_r;
         out_len_r <= out_len_r;
      end
   end

   assign in_ready   = in_ready_r;
   assign out_valid  = out_valid_r;
   assign err        = err_r;
   assign out_sum    = out_sum_r;
   assign out_gt_cnt = out_gt_r;
   assign out_eq_cnt = out_eq_r;
   assign out_lt_cnt = out_lt_r;
   assign out_len    = out_len_r;

endmodule

// File: tb/tb_cmp_window_tally.sv
// Testbench for cmp_window_tally: directed scenarios followed by random
// traffic, all checked every cycle against a queue-based window model.
module tb_cmp_window_tally;

   localparam int WINDOW = 8;
   localparam int CNT_W  = $clog2(WINDOW + 1);
   localparam int SUM_W  = CNT_W + 1;

   logic             clk;
   logic             rstn;
   logic             in_valid;
   logic [4:0]       in_result;
   logic             in_ready;
   logic             flush;
   logic             err_clr;
   logic             out_valid;
   logic             out_ready;
   logic [SUM_W-1:0] out_sum;
   logic [CNT_W-1:0] out_gt_cnt;
   logic [CNT_W-1:0] out_eq_cnt;
   logic [CNT_W-1:0] out_lt_cnt;
   logic [CNT_W-1:0] out_len;
   logic             err;

   cmp_window_tally #(.WINDOW(WINDOW)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_result  (in_result),
      .in_ready   (in_ready),
      .flush      (flush),
      .err_clr    (err_clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sum    (out_sum),
      .out_gt_cnt (out_gt_cnt),
      .out_eq_cnt (out_eq_cnt),
      .out_lt_cnt (out_lt_cnt),
      .out_len    (out_len),
      .err        (err)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the current window as a list of accepted values.
   int q[$];
   bit m_rep;
   bit m_err;
   int e_sum, e_gt, e_eq, e_lt, e_len;

   int n_chk;
   int n_pass;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all(input string where);
      int s;
      s = $signed(out_sum);
      check_val({where, ".in_ready"},  int'(in_ready),  int'(!m_rep));
      check_val({where, ".out_valid"}, int'(out_valid), int'(m_rep));
      check_val({where, ".err"},       int'(err),       int'(m_err));
      check_val({where, ".sum"},       s,               e_sum);
      check_val({where, ".gt"},        int'(out_gt_cnt), e_gt);
      check_val({where, ".eq"},        int'(out_eq_cnt), e_eq);
      check_val({where, ".lt"},        int'(out_lt_cnt), e_lt);
      check_val({where, ".len"},       int'(out_len),   e_len);
   endtask

   task automatic model_reset();
      q.delete();
      m_rep = 1'b0;
      m_err = 1'b0;
      e_sum = 0; e_gt = 0; e_eq = 0; e_lt = 0; e_len = 0;
   endtask

   // Apply the specification's rules for one rising edge.
   task automatic model_edge(input bit v, input logic [4:0] code, input bit fl,
                             input bit ec, input bit ordy);
      bit legal;
      bit acc;
      int val;
      legal = (code == 5'b00001) || (code == 5'b00000) || (code == 5'b11111);
      val   = (code == 5'b00001) ? 1 : ((code == 5'b00000) ? 0 : -1);
      acc   = v && !m_rep;
      if (acc && !legal) m_err = 1'b1;
      else if (ec) m_err = 1'b0;
      if (!m_rep) begin
         if (acc && legal) q.push_back(val);
         if ((acc && legal && q.size() == WINDOW) || (fl && q.size() > 0)) begin
            e_sum = 0; e_gt = 0; e_eq = 0; e_lt = 0;
            foreach (q[k]) begin
               e_sum += q[k];
               if (q[k] > 0) e_gt++;
               else if (q[k] == 0) e_eq++;
               else e_lt++;
            end
            e_len = q.size();
            q.delete();
            m_rep = 1'b1;
         end
      end else if (ordy) begin
         m_rep = 1'b0;
      end
   endtask

   // One clock cycle of stimulus, model update and full output check.
   task automatic step(input bit v, input logic [4:0] code, input bit fl,
                       input bit ec, input bit ordy, input string tag);
      in_valid  = v;
      in_result = code;
      flush     = fl;
      err_clr   = ec;
      out_ready = ordy;
      @(posedge clk);
      model_edge(v, code, fl, ec, ordy);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse taken between clock edges.
   task automatic do_reset(input string tag);
      in_valid = 1'b0;
      flush    = 1'b0;
      err_clr  = 1'b0;
      out_ready = 1'b1;
      rstn     = 1'b0;
      #2;
      model_reset();
      check_all({tag, ".async"});
      @(negedge clk);
      rstn = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check_all({tag, ".idle"});
      end
   endtask

   logic [4:0] mixed [8];
   logic [4:0] rc;
   int         r;

   initial begin
      n_chk     = 0;
      n_pass    = 0;
      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_result = 5'b00000;
      flush     = 1'b0;
      err_clr   = 1'b0;
      out_ready = 1'b1;
      model_reset();
      #12;
      do_reset("init");

      // Eight +1 codes with the sink always ready.
      for (int i = 0; i < 8; i++) step(1'b1, 5'b00001, 1'b0, 1'b0, 1'b1, "plus8");
      step(1'b1, 5'b00001, 1'b0, 1'b0, 1'b1, "plus8_ack");
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, "plus8_after");

      // Mixed window, then an all -1 window.
      mixed[0] = 5'b00001; mixed[1] = 5'b00001; mixed[2] = 5'b11111; mixed[3] = 5'b00000;
      mixed[4] = 5'b11111; mixed[5] = 5'b11111; mixed[6] = 5'b00000; mixed[7] = 5'b00001;
      for (int i = 0; i < 8; i++) step(1'b1, mixed[i], 1'b0, 1'b0, 1'b1, "mixed");
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, "mixed_ack");
      for (int i = 0; i < 8; i++) step(1'b1, 5'b11111, 1'b0, 1'b0, 1'b1, "minus8");
      check_val("minus8.raw_bits", int'(out_sum), 24);
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, "minus8_ack");

      // Backpressure: held report, extra samples ignored, then release.
      for (int i = 0; i < 8; i++) step(1'b1, mixed[i], 1'b0, 1'b0, 1'b0, "bp_fill");
      for (int i = 0; i < 5; i++) step(1'b1, 5'b00001, 1'b0, 1'b0, 1'b0, "bp_hold");
      step(1'b1, 5'b00001, 1'b1, 1'b0, 1'b1, "bp_release");
      for (int i = 0; i < 8; i++) step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b1, "bp_next");
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, "bp_next_ack");

      // Illegal codes interleaved with legal ones.
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 5'b00010, 1'b0, 1'b0, 1'b1, "illegal");
         step(1'b1, 5'b00001, 1'b0, 1'b0, 1'b1, "illegal_legal");
      end
      step(1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, "err_clr");
      step(1'b1, 5'b00010, 1'b0, 1'b1, 1'b1, "err_clr_vs_set");
      step(1'b0, 5'b00000, 1'b0, 1'b1, 1'b1, "err_clr2");

      // Flush cases: partial window, empty window, coincident sample.
      step(1'b1, 5'b00001, 1'b0, 1'b0, 1'b1, "fl_a");
      step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b1, "fl_b");
      step(1'b1, 5'b11111, 1'b0, 1'b0, 1'b1, "fl_c");
      step(1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, "fl_go");
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, "fl_ack");
      step(1'b0, 5'b00000, 1'b1, 1'b0, 1'b1, "fl_empty");
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, "fl_empty2");
      step(1'b1, 5'b00001, 1'b0, 1'b0, 1'b1, "fl4_a");
      step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b1, "fl4_b");
      step(1'b1, 5'b11111, 1'b0, 1'b0, 1'b1, "fl4_c");
      step(1'b1, 5'b00001, 1'b1, 1'b0, 1'b0, "fl4_go");
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, "fl4_ack");

      // Reset mid-window and mid-report.
      for (int i = 0; i < 5; i++) step(1'b1, 5'b00001, 1'b0, 1'b0, 1'b1, "rst_pre");
      do_reset("rst_mid");
      for (int i = 0; i < 8; i++) step(1'b1, 5'b11111, 1'b0, 1'b0, 1'b0, "rst_post");
      do_reset("rst_rep");
      for (int i = 0; i < 8; i++) step(1'b1, 5'b00000, 1'b0, 1'b0, 1'b1, "rst_post2");
      step(1'b0, 5'b00000, 1'b0, 1'b0, 1'b1, "rst_post2_ack");

      // Random traffic.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(199) == 0) begin
            do_reset("rnd_rst");
         end else begin
            r = $urandom_range(15);
            if (r < 5)       rc = 5'b00001;
            else if (r < 10) rc = 5'b00000;
            else if (r < 15) rc = 5'b11111;
            else             rc = 5'($urandom);
            step(($urandom_range(3) != 0), rc, ($urandom_range(19) == 0),
                 ($urandom_range(19) == 0), ($urandom_range(9) < 7), "rnd");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cmp_window_tally.md
Name: cmp_window_tally

Overview:
- Consumes the 5-bit comparison code stream from the operand comparer: +1 = 5'b00001, 0 = 5'b00000, -1 = 5'b11111.
- Accumulates codes over a fixed window of WINDOW accepted samples and reports a signed net sum plus per-class counts through a valid/ready output.
- Sits directly downstream of the comparer inside the same reconfigurable region.
- Flags illegal codes with a sticky error.

Parameters:
- WINDOW, 8, number of legal samples per report; legal range 2..255.
- CNT_W, derived localparam = clog2(WINDOW+1), width of each count output.
- SUM_W, derived localparam = CNT_W+1, width of the signed net sum.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  in_result holds a sample.
- in_result  in  5  comparison code.
- in_ready  out  1  block accepts a sample this cycle.
- flush  in  1  force an early report of a partial window.
- err_clr  in  1  clear the sticky error.
- out_valid  out  1  report fields are valid.
- out_ready  in  1  downstream accepts the report.
- out_sum  out  SUM_W  signed two's-complement net sum, gt_cnt minus lt_cnt.
- out_gt_cnt  out  CNT_W  count of +1 codes.
- out_eq_cnt  out  CNT_W  count of 0 codes.
- out_lt_cnt  out  CNT_W  count of -1 codes.
- out_len  out  CNT_W  legal samples in this report.
- err  out  1  sticky illegal-code flag.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-low (rstn). Reset is sampled asynchronously on assert and released synchronously to clk.
- Reset values: state=ACCUM, all counters 0, out_valid=0, in_ready=1, err=0. All out_* data fields are 0.
- States: ACCUM and REPORT.
- ACCUM:
  - in_ready=1.
  - A sample is accepted when in_valid && in_ready at a rising edge.
  - A legal code increments the matching class counter and len.
  - An illegal code (any other value) sets err and changes no counter or len.
- ACCUM -> REPORT on the edge where len reaches WINDOW through an accepted legal sample.
- ACCUM -> REPORT on the edge where flush=1 and the resulting len > 0.
  - If a legal sample is accepted in the same cycle, it is counted first, then the report is taken.
  - flush with resulting len=0 is ignored.
- Report capture: on entry to REPORT, the out_* fields are loaded from the final counters and out_valid=1 from the next cycle. Latency from the last accepted sample to out_valid=1 is 1 cycle.
- REPORT:
  - in_ready=0; samples and flush are ignored.
  - out_* fields stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0, counters clear, return to ACCUM, and in_ready=1 in the next cycle.
  - A continuous stream therefore loses exactly one cycle per report.
- Arithmetic:
  - Counters never exceed WINDOW, so no wrap.
  - out_sum = gt_cnt - lt_cnt, sign-extended to SUM_W. Range -WINDOW..+WINDOW.
  - out_len = gt+eq+lt.
- err behaviour:
  - err stays set until err_clr=1 or reset.
  - If err_clr and an illegal sample occur in the same cycle, set wins and err=1.
  - err does not block accumulation.
- Reset mid-window or mid-REPORT: all state is discarded immediately and the partial window is not reported.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- WINDOW=8, eight consecutive 5'b00001 with out_ready=1 -> one report, 1 cycle after the 8th accept: out_sum=+8, gt=8, eq=0, lt=0, len=8. in_ready=0 for exactly 1 cycle.
- Mixed stream +1,+1,-1,0,-1,-1,0,+1 -> out_sum=0, gt=3, eq=2, lt=3, len=8. A second window of eight 5'b11111 -> out_sum=-8 (5'b11000).
- Backpressure: out_ready=0 for 5 cycles after a report -> out_valid held, fields unchanged, in_ready=0, extra in_valid samples not counted. Then out_ready=1 -> next window starts from zero.
- Illegal codes: stream 5'b00010 between legal samples -> err=1, len unaffected, the report still needs 8 legal samples. err_clr clears err. err_clr coincident with an illegal code -> err=1.
- Flush: 3 samples (+1,0,-1) then flush -> out_sum=0, len=3. Flush with len=0 -> no report. Flush with a coincident 4th sample +1 -> len=4, out_sum=+1.
- Reset: rstn low after 5 samples, and again while out_valid=1 -> out_valid=0 and counters 0 immediately. The next window reports only post-reset samples.
